// File: rtl/game_state_controller_if.sv
// Bundle of the scene sequencer's data-path signals.
//   master : drives the scan position, encounter/battle/transition inputs and XP gain.
//   slave  : the sequencer. It drives state, transition start, level, XP, evolve and stage.
interface game_state_controller_if;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        encounter_in;
  logic        transition_done_in;
  logic        battle_over_in;
  logic        battle_won_in;
  logic [7:0]  xp_gain_in;
  logic [2:0]  state_out;
  logic        transition_start_out;
  logic [7:0]  level_out;
  logic [7:0]  xp_out;
  logic        evolve_out;
  logic [1:0]  evo_stage_out;

  modport master (
    output hcount, vcount, encounter_in, transition_done_in, battle_over_in, battle_won_in,
           xp_gain_in,
    input  state_out, transition_start_out, level_out, xp_out, evolve_out, evo_stage_out
  );

  modport slave (
    input  hcount, vcount, encounter_in, transition_done_in, battle_over_in, battle_won_in,
           xp_gain_in,
    output state_out, transition_start_out, level_out, xp_out, evolve_out, evo_stage_out
  );
endinterface

// File: rtl/game_state_controller.sv
// Top-level scene sequencer: overworld -> transition -> battle -> award -> (evolve) -> overworld.
// Keeps the player's level, XP, XP requirement, evolve threshold and evolution stage.
// Ports:
//   clk_in : pixel clock
//   rst_in : asynchronous active-low reset
//   bus    : slave side of game_state_controller_if (scan position, scene inputs, all outputs)
// Every output comes straight from a flop.
module game_state_controller #(
  parameter logic [7:0] INIT_LEVEL         = 8'd5,
  parameter logic [7:0] XP_STEP            = 8'd10,
  parameter logic [7:0] INIT_EVOLVE_LEVEL  = 8'd16,
  parameter logic [7:0] EVOLVE_STEP        = 8'd20,
  parameter logic [7:0] MAX_LEVEL          = 8'd100,
  parameter logic [7:0] EVOLVE_FRAMES      = 8'd120,
  parameter logic [7:0] TRANSITION_TIMEOUT = 8'd90
) (
  input logic                    clk_in,
  input logic                    rst_in,
  game_state_controller_if.slave bus
);

  typedef enum logic [2:0] {
    StOverworld  = 3'b001,
    StTransition = 3'b010,
    StBattle     = 3'b100,
    StAward      = 3'b110,
    StEvolve     = 3'b011
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] level_q, level_d;
  logic [7:0] xp_q, xp_d;
  logic [7:0] xp_req_q, xp_req_d;
  logic [7:0] evolve_level_q, evolve_level_d;
  logic [1:0] evo_stage_q, evo_stage_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       trans_start_q, trans_start_d;
  logic       evolve_q, evolve_d;

  logic       frame_tick;
  logic [7:0] frame_cnt_inc;
  logic [8:0] xp_sum;
  logic [8:0] level_inc;
  logic [8:0] xp_req_sum;
  logic [8:0] evolve_level_sum;

  assign frame_tick = (bus.hcount == 11'd0) && (bus.vcount == 10'd0);

  // Frame counter saturates at 255 rather than wrapping.
  assign frame_cnt_inc    = (frame_tick && (frame_cnt_q != 8'hFF)) ? frame_cnt_q + 8'd1
                                                                    : frame_cnt_q;
  assign xp_sum           = {1'b0, xp_q} + {1'b0, bus.xp_gain_in};
  assign level_inc        = {1'b0, level_q} + 9'd1;
  assign xp_req_sum       = {1'b0, xp_req_q} + {1'b0, XP_STEP};
  assign evolve_level_sum = {1'b0, evolve_level_q} + {1'b0, EVOLVE_STEP};

  always_comb begin
    state_d        = state_q;
    level_d        = level_q;
    xp_d           = xp_q;
    xp_req_d       = xp_req_q;
    evolve_level_d = evolve_level_q;
    evo_stage_d    = evo_stage_q;
    frame_cnt_d    = frame_cnt_q;

    unique case (state_q)
      StOverworld: begin
        if (bus.encounter_in) begin
          state_d     = StTransition;
          frame_cnt_d = 8'd0;
        end
      end
      StTransition: begin
        frame_cnt_d = frame_cnt_inc;
        // Done and timeout both land in battle, so no priority question arises.
        if (bus.transition_done_in || (frame_cnt_inc >= TRANSITION_TIMEOUT)) begin
          state_d = StBattle;
        end
      end
      StBattle: begin
        if (bus.battle_over_in) begin
          if (bus.battle_won_in) begin
            xp_d    = xp_sum[8] ? 8'hFF : xp_sum[7:0];
            state_d = StAward;
          end else begin
            state_d = StOverworld;
          end
        end
      end
      StAward: begin
        state_d = StOverworld;
        // At most one level-up per battle; surplus XP carries to the next check.
        if ((xp_q >= xp_req_q) && (level_q < MAX_LEVEL)) begin
          level_d  = level_inc[7:0];
          xp_req_d = xp_req_sum[8] ? 8'hFF : xp_req_sum[7:0];
          if ((level_inc >= {1'b0, evolve_level_q}) && (evo_stage_q < 2'd2)) begin
            evo_stage_d    = evo_stage_q + 2'd1;
            evolve_level_d = evolve_level_sum[8] ? 8'hFF : evolve_level_sum[7:0];
            frame_cnt_d    = 8'd0;
            state_d        = StEvolve;
          end
        end
      end
      StEvolve: begin
        frame_cnt_d = frame_cnt_inc;
        if (frame_cnt_inc >= EVOLVE_FRAMES) begin
          state_d = StOverworld;
        end
      end
      default: begin
        state_d = StOverworld;
      end
    endcase

    // Decoded from next state so these flags line up with state_out.
    trans_start_d = (state_d == StTransition);
    evolve_d      = (state_d == StEvolve);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q        <= StOverworld;
      level_q        <= INIT_LEVEL;
      xp_q           <= 8'd0;
      xp_req_q       <= XP_STEP;
      evolve_level_q <= INIT_EVOLVE_LEVEL;
      evo_stage_q    <= 2'd0;
      frame_cnt_q    <= 8'd0;
      trans_start_q  <= 1'b0;
      evolve_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      xp_q           <= xp_d;
      xp_req_q       <= xp_req_d;
      evolve_level_q <= evolve_level_d;
      evo_stage_q    <= evo_stage_d;
      frame_cnt_q    <= frame_cnt_d;
      trans_start_q  <= trans_start_d;
      evolve_q       <= evolve_d;
    end
  end

  assign bus.state_out            = state_q;
  assign bus.transition_start_out = trans_start_q;
  assign bus.level_out            = level_q;
  assign bus.xp_out               = xp_q;
  assign bus.evolve_out           = evolve_q;
  assign bus.evo_stage_out        = evo_stage_q;

endmodule

// File: tb/tb_game_state_controller.sv
// Randomized bench for game_state_controller. Stimulus tasks advance a scene-level model and
// queue the output snapshot expected at each output change; a negedge monitor pops and
// compares whenever the DUT outputs change.
module tb_game_state_controller;

  localparam logic [2:0] OW = 3'b001, TR = 3'b010, BA = 3'b100, AW = 3'b110, EV = 3'b011;
  localparam int LVL0 = 5, XP_STEP = 10, EVO0 = 16, EVO_STEP = 20, MAX_LVL = 100;
  localparam int EVO_FRAMES = 120, TIMEOUT = 90;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  game_state_controller_if bus ();

  game_state_controller dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [22:0] vec;
  } exp_t;
  exp_t exp_q[$];

  // Scene-level reference model.
  logic [2:0] m_scene;
  int m_level, m_xp, m_req, m_evo, m_stage, m_frames;

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic bit coin(input int one_in);
    return $urandom_range(0, one_in - 1) == 0;
  endfunction

  function automatic logic [22:0] model_vec();
    return {m_scene, (m_scene == TR), 8'(m_level), 8'(m_xp), (m_scene == EV), 2'(m_stage)};
  endfunction

  function automatic logic [22:0] dut_vec();
    return {bus.state_out, bus.transition_start_out, bus.level_out, bus.xp_out,
            bus.evolve_out, bus.evo_stage_out};
  endfunction

  task automatic model_reset();
    m_scene  = OW;
    m_level  = LVL0;
    m_xp     = 0;
    m_req    = XP_STEP;
    m_evo    = EVO0;
    m_stage  = 0;
    m_frames = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic push_exp(input int at_cyc);
    exp_t e;
    e.cyc = at_cyc;
    e.vec = model_vec();
    exp_q.push_back(e);
  endtask

  // Monitor: every output change must match the oldest queued expectation, at its cycle.
  logic [22:0] prev_vec;
  always @(negedge clk_in) begin : monitor
    logic [22:0] cur;
    exp_t        e;
    cur = dut_vec();
    if (mon_en && (cur !== prev_vec)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_change", 32'(cur), 32'(prev_vec));
      end else begin
        e = exp_q.pop_front();
        check("out_vec", 32'(cur), 32'(e.vec));
        check("out_cycle", cyc, e.cyc);
      end
    end
    prev_vec = cur;
  end

  // Applies one cycle of inputs (called just after a rising edge); pulses self-clear.
  task automatic drive(input bit enc, input bit done, input bit over, input bit won,
                       input logic [7:0] gain, input bit tick);
    bus.encounter_in       = enc;
    bus.transition_done_in = done;
    bus.battle_over_in     = over;
    bus.battle_won_in      = won;
    bus.xp_gain_in         = gain;
    if (tick) begin
      bus.hcount = 11'd0;
      bus.vcount = 10'd0;
    end else begin
      bus.hcount = 11'($urandom_range(1, 1599));
      bus.vcount = 10'($urandom_range(0, 599));
    end
    @(posedge clk_in);
    #1;
    bus.encounter_in       = 1'b0;
    bus.transition_done_in = 1'b0;
    bus.battle_over_in     = 1'b0;
    bus.hcount             = 11'd1;
  endtask

  function automatic logic [7:0] rgain();
    return 8'($urandom_range(0, 255));
  endfunction

  task automatic do_reset();
    rst_in = 1'b0;
    model_reset();
    push_exp(cyc);
    #1;
    check("async_reset", 32'(dut_vec()), 32'(model_vec()));
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
  endtask

  task automatic do_encounter();
    repeat ($urandom_range(0, 2)) drive(0, coin(3), coin(3), coin(2), rgain(), coin(3));
    m_scene  = TR;
    m_frames = 0;
    push_exp(cyc + 1);
    drive(1, coin(3), coin(3), coin(2), rgain(), coin(3));
  endtask

  // k frame ticks; if finish, then a done pulse (optionally on a tick) unless timed out.
  task automatic run_transition(input int k, input bit done_tick, input bit finish);
    for (int i = 0; i < k && m_scene == TR; i++) begin
      repeat ($urandom_range(0, 2)) drive(coin(3), 0, coin(3), coin(2), rgain(), 0);
      m_frames++;
      if (m_frames >= TIMEOUT) begin
        m_scene = BA;
        push_exp(cyc + 1);
      end
      drive(coin(3), 0, coin(3), coin(2), rgain(), 1);
    end
    if (finish && m_scene == TR) begin
      m_scene = BA;
      push_exp(cyc + 1);
      drive(0, 1, coin(3), coin(2), rgain(), done_tick);
    end
  endtask

  task automatic do_battle(input bit won, input logic [7:0] gain);
    repeat ($urandom_range(0, 3)) drive(coin(3), coin(3), 0, coin(2), rgain(), coin(3));
    if (won) begin
      m_xp    = min2(m_xp + int'(gain), 255);
      m_scene = AW;
      push_exp(cyc + 1);
      drive(coin(3), coin(3), 1, 1, gain, coin(3));
      m_scene = OW;
      if (m_xp >= m_req && m_level < MAX_LVL) begin
        m_level++;
        m_req = min2(m_req + XP_STEP, 255);
        if (m_level >= m_evo && m_stage < 2) begin
          m_stage++;
          m_evo    = min2(m_evo + EVO_STEP, 255);
          m_frames = 0;
          m_scene  = EV;
        end
      end
      push_exp(cyc + 1);
      drive(coin(3), coin(3), coin(3), coin(2), rgain(), coin(3));
    end else begin
      m_scene = OW;
      push_exp(cyc + 1);
      drive(coin(3), coin(3), 1, 0, gain, coin(3));
    end
  endtask

  // abort_at > 0 drops reset right after that many evolve frames.
  task automatic run_evolve(input int abort_at);
    for (int i = 0; i < 200 && m_scene == EV; i++) begin
      repeat ($urandom_range(0, 1)) drive(coin(3), coin(3), coin(3), coin(2), rgain(), 0);
      m_frames++;
      if (m_frames >= EVO_FRAMES) begin
        m_scene = OW;
        push_exp(cyc + 1);
      end
      drive(coin(3), coin(3), coin(3), coin(2), rgain(), 1);
      if (abort_at > 0 && m_frames == abort_at && m_scene == EV) do_reset();
    end
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation exceeded its time budget at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin : stimulus
    int k;
    bus.hcount             = 11'd1;
    bus.vcount             = 10'd0;
    bus.encounter_in       = 1'b0;
    bus.transition_done_in = 1'b0;
    bus.battle_over_in     = 1'b0;
    bus.battle_won_in      = 1'b0;
    bus.xp_gain_in         = 8'd0;
    model_reset();
    #2 rst_in = 1'b0;
    #1 check("reset_initial", 32'(dut_vec()), 32'(model_vec()));
    repeat (3) @(posedge clk_in);
    #1;
    check("reset_hold", 32'(dut_vec()), 32'(model_vec()));
    mon_en = 1'b1;
    rst_in = 1'b1;

    // Done-terminated transition, then a win worth 12 XP: one level-up to 6.
    do_encounter();
    run_transition(3, 0, 1);
    do_battle(1, 8'd12);
    check("first_levelup", 32'(bus.level_out), 32'd6);

    // Timeout exit, then a lost battle that must not touch XP.
    do_encounter();
    run_transition(200, 0, 1);
    do_battle(0, 8'd50);
    check("loss_keeps_xp", 32'(bus.xp_out), 32'd12);

    // Done arriving on the same tick as the timeout.
    do_encounter();
    run_transition(TIMEOUT - 1, 1, 1);
    do_battle(0, 8'd7);

    // Random campaign to the level cap, through both evolutions.
    for (int b = 0; b < 400 && m_level < MAX_LVL; b++) begin
      do_encounter();
      k = coin(15) ? 95 : $urandom_range(0, 12);
      run_transition(k, coin(2), 1);
      do_battle(!coin(5), 8'($urandom_range(0, 40)));
      if (m_scene == EV) run_evolve(0);
    end
    check("level_capped", 32'(bus.level_out), 32'(MAX_LVL));
    check("stage_capped", 32'(bus.evo_stage_out), 32'd2);
    repeat (3) begin
      do_encounter();
      run_transition($urandom_range(0, 5), 0, 1);
      do_battle(1, rgain());
    end

    // Reset mid-transition.
    do_encounter();
    run_transition(30, 0, 0);
    do_reset();

    // Climb to the first evolution again and reset partway through it.
    for (int b = 0; b < 60 && m_scene != EV; b++) begin
      do_encounter();
      run_transition($urandom_range(0, 4), coin(2), 1);
      do_battle(1, 8'($urandom_range(30, 40)));
    end
    check("reached_evolve", 32'(bus.evolve_out), 32'd1);
    run_evolve(50);

    // Normal operation after reset.
    do_encounter();
    run_transition(2, 0, 1);
    do_battle(1, 8'd12);
    repeat (4) drive(0, 0, 0, 0, 8'd0, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_state_controller.md
Name: game_state_controller

Overview:
- Top-level scene sequencer for the game.
- Moves between overworld, battle-transition animation, battle, XP award and evolution.
- Drives the level-held start of the bar-wipe transition block and consumes its done flag.
- Owns the player level/XP bookkeeping and the evolution trigger that the display muxes and sprite selectors read.

Parameters:
- INIT_LEVEL, 8'd5, level after reset
- XP_STEP, 8'd10, initial XP requirement and increment per level-up
- INIT_EVOLVE_LEVEL, 8'd16, first level that triggers evolution
- EVOLVE_STEP, 8'd20, added to the evolve threshold after each evolution
- MAX_LEVEL, 8'd100, level saturation value
- EVOLVE_FRAMES, 8'd120, frames spent in EVOLVE
- TRANSITION_TIMEOUT, 8'd90, frames in TRANSITION before forced entry to BATTLE

Ports:
- clk_in  in  1  pixel clock
- rst_in  in  1  asynchronous, active-low reset
- hcount  in  11  current pixel x
- vcount  in  10  current pixel y
- encounter_in  in  1  1-cycle pulse from overworld logic: wild encounter
- transition_done_in  in  1  done from transition animation block
- battle_over_in  in  1  1-cycle pulse: battle finished
- battle_won_in  in  1  qualifies battle_over_in
- xp_gain_in  in  8  XP earned; sampled with battle_over_in
- state_out  out  3  001 OVERWORLD, 010 TRANSITION, 100 BATTLE, 110 AWARD, 011 EVOLVE
- transition_start_out  out  1  held high for the whole TRANSITION state
- level_out  out  8  current level
- xp_out  out  8  accumulated XP, saturating
- evolve_out  out  1  high while in EVOLVE
- evo_stage_out  out  2  evolution stage 0..2

Behaviour:
- frame_tick = (hcount==0 && vcount==0). It is true for one cycle per frame.
- Reset (rst_in low, asynchronous) forces:
  - state_out=001, transition_start_out=0, level_out=INIT_LEVEL, xp_out=0, evolve_out=0, evo_stage_out=0
  - xp_req=XP_STEP, evolve_level=INIT_EVOLVE_LEVEL, frame counter=0
  - This applies mid-operation in any state. transition_start_out drops immediately.
- All outputs are registered. All transitions occur on the clock edge that samples the condition.
- OVERWORLD:
  - encounter_in=1 -> TRANSITION. Clear the frame counter; transition_start_out=1 from the next cycle.
- TRANSITION:
  - On frame_tick, frame counter +1.
  - transition_done_in=1 -> BATTLE, transition_start_out=0.
  - Otherwise, when the counter reaches TRANSITION_TIMEOUT -> BATTLE (safety exit).
  - done and timeout in the same cycle: take the done path; the result is identical.
- BATTLE:
  - battle_over_in=1 with battle_won_in=1: xp_out <= min(xp_out + xp_gain_in, 255), using a 9-bit sum then saturation. State -> AWARD.
  - battle_over_in=1 with battle_won_in=0: xp unchanged, state -> OVERWORLD.
- AWARD (exactly 1 cycle):
  - If xp_out >= xp_req and level_out < MAX_LEVEL: level_out +1, and xp_req += XP_STEP saturating at 255.
  - If additionally (level_out+1) >= evolve_level and evo_stage_out < 2:
    - evo_stage_out +1, evolve_level += EVOLVE_STEP saturating at 255, clear the frame counter, state -> EVOLVE.
  - Otherwise state -> OVERWORLD.
  - At most one level-up per battle. XP is cumulative and never decremented; surplus counts toward the next battle's check.
- EVOLVE:
  - evolve_out=1. Frame counter +1 per frame_tick.
  - When the counter reaches EVOLVE_FRAMES -> OVERWORLD, evolve_out=0.
- Ignored inputs:
  - encounter_in outside OVERWORLD.
  - battle_over_in outside BATTLE.
  - transition_done_in outside TRANSITION.
- The frame counter is 8 bits and saturates at 255; it never wraps.

Test Plan:
- Reset, encounter_in pulse -> next cycle state_out=010, transition_start_out=1. Assert transition_done_in -> state_out=100, transition_start_out=0 on the following cycle.
- Encounter, transition_done_in held 0 -> exactly 90 frame_ticks later state_out=100.
- In BATTLE, battle_over_in=1, battle_won_in=1, xp_gain_in=12 -> xp_out=12, state 110 for one cycle, then level_out=6, xp_req=20, state 001.
- Set level to 15 via prior wins (xp_req met), win again -> level_out=16, state 011, evolve_out=1, evo_stage_out=1. After 120 frames -> state 001, evolve_out=0; next evolve threshold is 36.
- xp_out=250, win with xp_gain_in=20 -> xp_out=255 (saturated). Lost battle with xp_gain_in=50 -> xp_out unchanged, state 001, no AWARD.
- Drop rst_in mid-TRANSITION and mid-EVOLVE -> outputs return to reset values asynchronously, without waiting for a clock edge. Encounter pulses during BATTLE are ignored.
